// File: rtl/wb_stage.sv
// wb_stage: MIPS writeback stage. Registers the MEM/WB boundary, aligns and
// extends load data, selects the writeback result and owns the architectural
// HI/LO pair.
//
// Pipeline control: i_con_validM marks a real instruction in M. The W register
// captures M whenever it is neither stalled nor flushed. Flush beats stall and
// inserts a bubble. A W-stage instruction with validW=1 is retired on the first
// edge at which the stage is not stalled. That rule makes the HI/LO commit
// happen exactly once.
module wb_stage #(
  parameter int DATA_W    = 32,
  parameter int REGADDR_W = 5,
  parameter bit HILO_EN   = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_con_stallW,
  input  logic                 i_con_flushW,
  input  logic                 i_con_validM,
  input  logic [DATA_W-1:0]    i_data_aluresM,
  input  logic [DATA_W-1:0]    i_data_readM,
  input  logic [1:0]           i_data_addrloM,
  input  logic [1:0]           i_con_ldsizeM,
  input  logic                 i_con_ldsignM,
  input  logic [1:0]           i_con_resselM,
  input  logic                 i_con_regwriteM,
  input  logic [REGADDR_W-1:0] i_addr_writeregM,
  input  logic                 i_con_hilowriteM,
  input  logic [DATA_W-1:0]    i_data_hiM,
  input  logic [DATA_W-1:0]    i_data_loM,
  output logic [DATA_W-1:0]    o_data_resultW,
  output logic [REGADDR_W-1:0] o_addr_writeregW,
  output logic                 o_con_regwriteW,
  output logic                 o_con_validW,
  output logic [DATA_W-1:0]    o_data_hi,
  output logic [DATA_W-1:0]    o_data_lo
);

  // Load lane extraction is written for a 32-bit word only.
  if (DATA_W != 32) begin : g_bad_width
    $error("wb_stage: DATA_W must be 32");
  end

  // W register fields
  logic                 valid_q, valid_d;
  logic [DATA_W-1:0]    alures_q, alures_d;
  logic [DATA_W-1:0]    read_q, read_d;
  logic [1:0]           addrlo_q, addrlo_d;
  logic [1:0]           ldsize_q, ldsize_d;
  logic                 ldsign_q, ldsign_d;
  logic [1:0]           ressel_q, ressel_d;
  logic                 regwrite_q, regwrite_d;
  logic [REGADDR_W-1:0] writereg_q, writereg_d;
  logic                 hilowrite_q, hilowrite_d;
  logic [DATA_W-1:0]    hin_q, hin_d;
  logic [DATA_W-1:0]    lin_q, lin_d;

  // Architectural HI/LO
  logic [DATA_W-1:0]    hi_q, hi_d;
  logic [DATA_W-1:0]    lo_q, lo_d;

  logic                 commit;
  logic [DATA_W-1:0]    load_val;

  // Next-state for the W register: flush > stall (hold) > capture.
  always_comb begin
    valid_d     = valid_q;
    alures_d    = alures_q;
    read_d      = read_q;
    addrlo_d    = addrlo_q;
    ldsize_d    = ldsize_q;
    ldsign_d    = ldsign_q;
    ressel_d    = ressel_q;
    regwrite_d  = regwrite_q;
    writereg_d  = writereg_q;
    hilowrite_d = hilowrite_q;
    hin_d       = hin_q;
    lin_d       = lin_q;
    if (i_con_flushW) begin
      valid_d     = 1'b0;
      alures_d    = '0;
      read_d      = '0;
      addrlo_d    = '0;
      ldsize_d    = '0;
      ldsign_d    = 1'b0;
      ressel_d    = '0;
      regwrite_d  = 1'b0;
      writereg_d  = '0;
      hilowrite_d = 1'b0;
      hin_d       = '0;
      lin_d       = '0;
    end else if (!i_con_stallW) begin
      valid_d     = i_con_validM;
      alures_d    = i_data_aluresM;
      read_d      = i_data_readM;
      addrlo_d    = i_data_addrloM;
      ldsize_d    = i_con_ldsizeM;
      ldsign_d    = i_con_ldsignM;
      ressel_d    = i_con_resselM;
      regwrite_d  = i_con_regwriteM;
      writereg_d  = i_addr_writeregM;
      hilowrite_d = i_con_hilowriteM;
      hin_d       = i_data_hiM;
      lin_d       = i_data_loM;
    end
  end

  // HI/LO commit when the W instruction retires; a concurrent flush does not block it.
  always_comb begin
    commit = valid_q & hilowrite_q & ~i_con_stallW;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (!HILO_EN) begin
      hi_d = '0;
      lo_d = '0;
    end else if (commit) begin
      hi_d = hin_q;
      lo_d = lin_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q     <= 1'b0;
      alures_q    <= '0;
      read_q      <= '0;
      addrlo_q    <= '0;
      ldsize_q    <= '0;
      ldsign_q    <= 1'b0;
      ressel_q    <= '0;
      regwrite_q  <= 1'b0;
      writereg_q  <= '0;
      hilowrite_q <= 1'b0;
      hin_q       <= '0;
      lin_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      valid_q     <= valid_d;
      alures_q    <= alures_d;
      read_q      <= read_d;
      addrlo_q    <= addrlo_d;
      ldsize_q    <= ldsize_d;
      ldsign_q    <= ldsign_d;
      ressel_q    <= ressel_d;
      regwrite_q  <= regwrite_d;
      writereg_q  <= writereg_d;
      hilowrite_q <= hilowrite_d;
      hin_q       <= hin_d;
      lin_q       <= lin_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  // Little-endian load lane selection and sign/zero extension.
  always_comb begin
    load_val = read_q;
    case (ldsize_q)
      2'b01: begin
        if (addrlo_q[1]) load_val = {{16{ldsign_q & read_q[31]}}, read_q[31:16]};
        else             load_val = {{16{ldsign_q & read_q[15]}}, read_q[15:0]};
      end
      2'b10: begin
        case (addrlo_q)
          2'd0:    load_val = {{24{ldsign_q & read_q[7]}},  read_q[7:0]};
          2'd1:    load_val = {{24{ldsign_q & read_q[15]}}, read_q[15:8]};
          2'd2:    load_val = {{24{ldsign_q & read_q[23]}}, read_q[23:16]};
          default: load_val = {{24{ldsign_q & read_q[31]}}, read_q[31:24]};
        endcase
      end
      default: load_val = read_q;
    endcase
  end

  // Writeback result mux and qualified write enable.
  always_comb begin
    case (ressel_q)
      2'b00:   o_data_resultW = alures_q;
      2'b01:   o_data_resultW = load_val;
      2'b10:   o_data_resultW = hi_q;
      default: o_data_resultW = lo_q;
    endcase
    o_con_regwriteW = valid_q & regwrite_q & (writereg_q != '0);
  end

  assign o_addr_writeregW = writereg_q;
  assign o_con_validW     = valid_q;
  assign o_data_hi        = hi_q;
  assign o_data_lo        = lo_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed and random checks of wb_stage against a transaction-level model.
module tb_wb_stage;

  typedef struct {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] rd;
    logic [1:0]  off;
    logic [1:0]  size;
    logic        sign;
    logic [1:0]  sel;
    logic        rw;
    logic [4:0]  wr;
    logic        hw;
    logic [31:0] hi;
    logic [31:0] lo;
  } txn_t;

  // clock / reset block
  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic        i_rst, i_con_stallW, i_con_flushW, i_con_validM;
  logic [31:0] i_data_aluresM, i_data_readM, i_data_hiM, i_data_loM;
  logic [1:0]  i_data_addrloM, i_con_ldsizeM, i_con_resselM;
  logic        i_con_ldsignM, i_con_regwriteM, i_con_hilowriteM;
  logic [4:0]  i_addr_writeregM;
  logic [31:0] o_data_resultW, o_data_hi, o_data_lo;
  logic [4:0]  o_addr_writeregW;
  logic        o_con_regwriteW, o_con_validW;

  wb_stage #(.DATA_W(32), .REGADDR_W(5), .HILO_EN(1'b1)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_con_stallW(i_con_stallW), .i_con_flushW(i_con_flushW),
    .i_con_validM(i_con_validM), .i_data_aluresM(i_data_aluresM), .i_data_readM(i_data_readM),
    .i_data_addrloM(i_data_addrloM), .i_con_ldsizeM(i_con_ldsizeM), .i_con_ldsignM(i_con_ldsignM),
    .i_con_resselM(i_con_resselM), .i_con_regwriteM(i_con_regwriteM),
    .i_addr_writeregM(i_addr_writeregM), .i_con_hilowriteM(i_con_hilowriteM),
    .i_data_hiM(i_data_hiM), .i_data_loM(i_data_loM),
    .o_data_resultW(o_data_resultW), .o_addr_writeregW(o_addr_writeregW),
    .o_con_regwriteW(o_con_regwriteW), .o_con_validW(o_con_validW),
    .o_data_hi(o_data_hi), .o_data_lo(o_data_lo)
  );

  int   n_checks = 0;
  int   n_fail   = 0;

  // reference model state: the instruction sitting in W plus architectural HI/LO
  txn_t w_m;
  logic [31:0] hi_m, lo_m;

  function automatic txn_t bubble();
    txn_t t;
    t.valid = 0; t.alu = 0; t.rd = 0; t.off = 0; t.size = 0; t.sign = 0;
    t.sel = 0; t.rw = 0; t.wr = 0; t.hw = 0; t.hi = 0; t.lo = 0;
    return t;
  endfunction

  function automatic txn_t mk(input logic [31:0] alu, input logic [31:0] rd, input logic [1:0] off,
                              input logic [1:0] size, input logic sign, input logic [1:0] sel,
                              input logic rw, input logic [4:0] wr);
    txn_t t = bubble();
    t.valid = 1; t.alu = alu; t.rd = rd; t.off = off; t.size = size; t.sign = sign;
    t.sel = sel; t.rw = rw; t.wr = wr;
    return t;
  endfunction

  // Load value from the rules: shift the wanted lane down, mask, then extend.
  function automatic logic [31:0] load_ref(input txn_t t);
    logic [31:0] v;
    if (t.size == 2'b10) begin
      v = (t.rd >> (8 * t.off)) & 32'hFF;
      if (t.sign && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end else if (t.size == 2'b01) begin
      v = (t.rd >> (t.off >= 2 ? 16 : 0)) & 32'hFFFF;
      if (t.sign && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end else begin
      v = t.rd;
    end
    return v;
  endfunction

  function automatic logic [31:0] result_ref(input txn_t t, input logic [31:0] hi, input logic [31:0] lo);
    case (t.sel)
      2'd0: return t.alu;
      2'd1: return load_ref(t);
      2'd2: return hi;
      default: return lo;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver: apply one cycle of M inputs/control, advance model, compare all outputs
  task automatic step(input txn_t m, input logic stall, input logic flush, input logic rst);
    i_rst = rst; i_con_stallW = stall; i_con_flushW = flush;
    i_con_validM = m.valid; i_data_aluresM = m.alu; i_data_readM = m.rd;
    i_data_addrloM = m.off; i_con_ldsizeM = m.size; i_con_ldsignM = m.sign;
    i_con_resselM = m.sel; i_con_regwriteM = m.rw; i_addr_writeregM = m.wr;
    i_con_hilowriteM = m.hw; i_data_hiM = m.hi; i_data_loM = m.lo;
    @(posedge i_clk);
    if (rst) begin
      w_m = bubble(); hi_m = 0; lo_m = 0;
    end else begin
      if (w_m.valid && w_m.hw && !stall) begin hi_m = w_m.hi; lo_m = w_m.lo; end
      if (flush) w_m = bubble();
      else if (!stall) w_m = m;
    end
    #1;
    check("result",   o_data_resultW, result_ref(w_m, hi_m, lo_m));
    check("writereg", {27'd0, o_addr_writeregW}, {27'd0, w_m.wr});
    check("regwrite", {31'd0, o_con_regwriteW}, {31'd0, w_m.valid && w_m.rw && (w_m.wr != 0)});
    check("valid",    {31'd0, o_con_validW}, {31'd0, w_m.valid});
    check("hi",       o_data_hi, hi_m);
    check("lo",       o_data_lo, lo_m);
  endtask

  initial begin
    txn_t t;
    txn_t mult;
    txn_t mfhi;
    w_m = bubble(); hi_m = 0; lo_m = 0;

    // reset then idle
    step(bubble(), 0, 0, 1);
    step(bubble(), 0, 0, 0);
    check("rst_valid", {31'd0, o_con_validW}, 32'd0);
    check("rst_result", o_data_resultW, 32'd0);
    check("rst_hi", o_data_hi, 32'd0);

    // ALU path
    step(mk(32'h1234_5678, 0, 0, 0, 0, 2'd0, 1, 5'd9), 0, 0, 0);
    check("alu_result", o_data_resultW, 32'h1234_5678);
    check("alu_wr", {27'd0, o_addr_writeregW}, 32'd9);
    check("alu_rw", {31'd0, o_con_regwriteW}, 32'd1);

    // load alignment
    step(mk(0, 32'h80FF_7F01, 2'd3, 2'b10, 1, 2'd1, 1, 5'd3), 0, 0, 0);
    check("lb_s3", o_data_resultW, 32'hFFFF_FF80);
    step(mk(0, 32'h80FF_7F01, 2'd2, 2'b10, 0, 2'd1, 1, 5'd3), 0, 0, 0);
    check("lbu_2", o_data_resultW, 32'h0000_00FF);
    step(mk(0, 32'h80FF_7F01, 2'd0, 2'b01, 1, 2'd1, 1, 5'd3), 0, 0, 0);
    check("lh_s0", o_data_resultW, 32'h0000_7F01);
    step(mk(0, 32'h80FF_7F01, 2'd2, 2'b01, 0, 2'd1, 1, 5'd3), 0, 0, 0);
    check("lhu_2", o_data_resultW, 32'h0000_80FF);

    // register zero suppression, then flush of a valid instruction
    step(mk(32'hDEAD_BEEF, 0, 0, 0, 0, 2'd0, 1, 5'd0), 0, 0, 0);
    check("r0_rw", {31'd0, o_con_regwriteW}, 32'd0);
    check("r0_valid", {31'd0, o_con_validW}, 32'd1);
    step(mk(32'h1, 0, 0, 0, 0, 2'd0, 1, 5'd4), 0, 1, 0);
    check("flush_valid", {31'd0, o_con_validW}, 32'd0);
    check("flush_rw", {31'd0, o_con_regwriteW}, 32'd0);

    // mult commit held by a 3-cycle stall, then mfhi
    mult = mk(0, 0, 0, 0, 0, 2'd0, 0, 5'd0);
    mult.hw = 1; mult.hi = 32'hA; mult.lo = 32'hB;
    mfhi = mk(0, 0, 0, 0, 0, 2'd2, 1, 5'd7);
    step(mult, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(mfhi, 1, 0, 0);
      check("stall_hi", o_data_hi, 32'd0);
    end
    step(mfhi, 0, 0, 0);
    check("commit_hi", o_data_hi, 32'hA);
    check("commit_lo", o_data_lo, 32'hB);
    check("mfhi_result", o_data_resultW, 32'hA);
    step(bubble(), 0, 0, 0);
    check("once_hi", o_data_hi, 32'hA);

    // reset mid-operation with stall, flush and a pending commit
    mult.hi = 32'h55; mult.lo = 32'h66;
    step(mult, 0, 0, 0);
    step(mfhi, 1, 1, 1);
    check("rstmid_hi", o_data_hi, 32'd0);
    check("rstmid_lo", o_data_lo, 32'd0);
    check("rstmid_valid", {31'd0, o_con_validW}, 32'd0);
    check("rstmid_result", o_data_resultW, 32'd0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      t = bubble();
      t.valid = ($urandom_range(0, 9) != 0);
      t.alu = $urandom; t.rd = $urandom;
      t.off = 2'($urandom_range(0, 3)); t.size = 2'($urandom_range(0, 3));
      t.sign = 1'($urandom_range(0, 1)); t.sel = 2'($urandom_range(0, 3));
      t.rw = 1'($urandom_range(0, 1)); t.wr = 5'($urandom_range(0, 31));
      t.hw = ($urandom_range(0, 3) == 0); t.hi = $urandom; t.lo = $urandom;
      step(t, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
